// File: rtl/rr_mux_arbiter.sv
// Purpose: N-channel WIDTH-bit valid/ready mux with round-robin or fixed-select arbitration into one output register.
// Latency: 1 cycle from the input handshake edge to out_valid; 1 transfer per cycle while out_ready is held high.
// Backpressure: when the output register is full and out_ready is low, every in_ready is low and the held value does not change.
module rr_mux_arbiter #(
  parameter  int WIDTH    = 3,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_q;
  state_t             state_d;
  logic [SEL_W-1:0]   ptr_q;
  logic [WIDTH-1:0]   out_data_q;
  logic [SEL_W-1:0]   out_chan_q;

  logic               load;
  logic               grant;
  logic               rr_found;
  logic [SEL_W-1:0]   rr_idx;
  logic [SEL_W-1:0]   rr_cand;
  logic               fx_found;
  logic               win_found;
  logic [SEL_W-1:0]   win_idx;

  // Round-robin search: first requester strictly after the last granted channel, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      rr_cand = SEL_W'((int'(ptr_q) + k) % CHANNELS);
      if (!rr_found && in_valid[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  // Winner selection; an out-of-range or idle fixed select yields no winner at all.
  always_comb begin
    fx_found  = (int'(sel) < CHANNELS) && in_valid[sel];
    win_found = mode ? fx_found : rr_found;
    win_idx   = mode ? sel : rr_idx;
  end

  // Load/grant decision, one-hot in_ready and output register next state.
  always_comb begin
    state_d  = state_q;
    in_ready = '0;
    load     = (state_q == EMPTY) || out_ready;
    grant    = rst_n && load && win_found;
    if (grant) begin
      in_ready[win_idx] = 1'b1;
    end
    if (grant) begin
      state_d = FULL;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  // Output register occupancy; reset discards any held transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture winning data/channel and move the priority pointer to the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_chan_q <= '0;
      ptr_q      <= SEL_W'(CHANNELS - 1);
    end else if (grant) begin
      out_data_q <= in_data[int'(win_idx)*WIDTH +: WIDTH];
      out_chan_q <= win_idx;
      ptr_q      <= win_idx;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Purpose: self-checking bench for rr_mux_arbiter with a transfer scoreboard and directed phases.
// Latency: expectations are pushed when a grant is driven and popped when the output handshakes.
// Backpressure: hold phases are checked directly against the held register value.
module tb_rr_mux_arbiter;

  localparam int WIDTH    = 3;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  logic                      clk;
  logic                      rst_n;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SEL_W-1:0]          out_chan;

  int checks = 0;
  int errors = 0;
  logic [SEL_W+WIDTH-1:0] sb[$];

  rr_mux_arbiter #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                          input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  task automatic expect_xfer(input logic [SEL_W-1:0] ch, input logic [WIDTH-1:0] d);
    sb.push_back({ch, d});
  endtask

  // Monitor: every output handshake must match the oldest expected transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got chan %0d data %0d, none expected at %0t", out_chan, out_data, $time);
      end else begin
        logic [SEL_W+WIDTH-1:0] e;
        e = sb.pop_front();
        chk("xfer_chan", 32'(out_chan), 32'(e[SEL_W+WIDTH-1:WIDTH]));
        chk("xfer_data", 32'(out_data), 32'(e[WIDTH-1:0]));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    // ---- Reset: everything valid, reset held ----
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    set_data(3'd1, 3'd2, 3'd3, 3'd4);
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_chan", 32'(out_chan), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("first_grant_rdy", 32'(in_ready), 32'b0001);
    step();
    chk("first_load_vld", 32'(out_valid), 32'h1);
    chk("first_load_chan", 32'(out_chan), 32'h0);
    chk("first_load_data", 32'(out_data), 32'h1);
    // Asynchronous reset pulse between edges discards the held value
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_vld", 32'(out_valid), 32'h0);
    chk("async_rst_data", 32'(out_data), 32'h0);
    chk("async_rst_chan", 32'(out_chan), 32'h0);
    chk("async_rst_rdy", 32'(in_ready), 32'h0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // ---- Round-robin full load: ch0..3 data 1..4 ----
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_in_ready", 32'(in_ready), 32'(1 << (i % 4)));
      expect_xfer(SEL_W'(i % 4), WIDTH'((i % 4) + 1));
      step();
    end
    in_valid = 4'b0000;
    step();
    chk("rr_drained", 32'(out_valid), 32'h0);

    // ---- Sparse wrap: set ptr=1 via ch1, then ch1+ch3 ----
    set_data(3'd0, 3'd6, 3'd0, 3'd2);
    in_valid = 4'b0010;
    #1;
    chk("sparse_setup_rdy", 32'(in_ready), 32'b0010);
    expect_xfer(2'd1, 3'd6);
    step();
    in_valid = 4'b1010;
    begin
      logic [3:0] rdy_exp [3];
      logic [1:0] ch_exp  [3];
      logic [2:0] d_exp   [3];
      rdy_exp = '{4'b1000, 4'b0010, 4'b1000};
      ch_exp  = '{2'd3, 2'd1, 2'd3};
      d_exp   = '{3'd2, 3'd6, 3'd2};
      for (int i = 0; i < 3; i++) begin
        #1;
        chk("sparse_rdy", 32'(in_ready), 32'(rdy_exp[i]));
        expect_xfer(ch_exp[i], d_exp[i]);
        step();
      end
    end
    in_valid = 4'b0000;
    step();

    // ---- Backpressure: hold 5 from ch0 for three cycles ----
    set_data(3'd5, 3'd7, 3'd3, 3'd4);
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    #1;
    chk("bp_load_rdy", 32'(in_ready), 32'b0001);
    expect_xfer(2'd0, 3'd5);
    step();
    in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rdy", 32'(in_ready), 32'h0);
      chk("bp_vld", 32'(out_valid), 32'h1);
      chk("bp_data", 32'(out_data), 32'h5);
      chk("bp_chan", 32'(out_chan), 32'h0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(in_ready), 32'b0010);
    expect_xfer(2'd1, 3'd7);
    step();
    in_valid = 4'b0000;
    step();

    // ---- Fixed mode: sel=2 wins over ch0 ----
    mode     = 1'b1;
    sel      = 2'd2;
    set_data(3'd7, 3'd0, 3'd5, 3'd0);
    in_valid = 4'b0101;
    #1;
    chk("fixed_rdy", 32'(in_ready), 32'b0100);
    expect_xfer(2'd2, 3'd5);
    step();
    sel = 2'd3;
    #1;
    chk("fixed_idle_rdy", 32'(in_ready), 32'h0);
    step();
    chk("fixed_idle_vld", 32'(out_valid), 32'h0);
    chk("fixed_keep_data", 32'(out_data), 32'h5);
    chk("fixed_keep_chan", 32'(out_chan), 32'h2);

    // ---- Mode switch while full and stalled ----
    mode      = 1'b0;
    out_ready = 1'b0;
    set_data(3'd1, 3'd2, 3'd3, 3'd4);
    in_valid  = 4'b1111;
    #1;
    chk("ms_rr_rdy", 32'(in_ready), 32'b1000);
    expect_xfer(2'd3, 3'd4);
    step();
    mode = 1'b1;
    sel  = 2'd1;
    #1;
    chk("ms_hold_rdy", 32'(in_ready), 32'h0);
    chk("ms_hold_data", 32'(out_data), 32'h4);
    chk("ms_hold_chan", 32'(out_chan), 32'h3);
    step();
    chk("ms_hold2_data", 32'(out_data), 32'h4);
    chk("ms_hold2_chan", 32'(out_chan), 32'h3);
    out_ready = 1'b1;
    #1;
    chk("ms_fixed_rdy", 32'(in_ready), 32'b0010);
    expect_xfer(2'd1, 3'd2);
    step();
    in_valid = 4'b0000;
    step();
    step();
    chk("end_vld", 32'(out_valid), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
